// File: rtl/mem_stage_lsu.sv
// MEM-stage load/store unit: req/ack data-memory handshake, sub-word load/store
// formatting, pipeline stall while an access is outstanding, misalign and timeout errors.
module mem_stage_lsu #(
   parameter int TIMEOUT = 255,
   parameter int CNT_W   = 8
) (
   input  logic        clk,
   input  logic        reset,
   input  logic        MemRead_mem,
   input  logic        MemWrite_mem,
   input  logic [2:0]  funct3_mem,
   input  logic [31:0] ALUResult_mem,
   input  logic [31:0] MemWriteData_mem,
   output logic        mem_req,
   output logic        mem_we,
   output logic [31:0] mem_addr,
   output logic [31:0] mem_wdata,
   output logic [3:0]  mem_wstrb,
   input  logic [31:0] mem_rdata,
   input  logic        mem_ack,
   output logic [31:0] MemDout_mem,
   output logic        stall_mem,
   output logic        misalign_err,
   output logic        bus_err
);

   typedef enum logic [1:0] {S_IDLE, S_WAIT, S_DONE} state_t;

   localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'((TIMEOUT > 0) ? TIMEOUT - 1 : 0);
   localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);

   state_t            state;
   logic [CNT_W-1:0]  cnt;
   logic              access, is_store, misaligned, issue;
   logic [1:0]        b;
   logic [31:0]       rsh, load_fmt, wdata_fmt;
   logic [15:0]       lhalf;
   logic [7:0]        lbyte;
   logic [3:0]        strb_fmt;

   assign access   = MemRead_mem | MemWrite_mem;
   assign is_store = MemWrite_mem;   // read+write together is treated as a store
   assign b        = ALUResult_mem[1:0];

   // Unsigned load sizes are not legal for stores; unknown encodings count as misaligned.
   always_comb begin
      misaligned = 1'b1;
      case (funct3_mem)
         3'b000:  misaligned = 1'b0;
         3'b001:  misaligned = b[0];
         3'b010:  misaligned = (b != 2'b00);
         3'b100:  misaligned = is_store;
         3'b101:  misaligned = is_store | b[0];
         default: misaligned = 1'b1;
      endcase
   end

   assign issue     = (state == S_IDLE) && access && !misaligned;
   assign mem_req   = !reset && (issue || (state == S_WAIT));
   assign mem_we    = mem_req && is_store;
   assign stall_mem = mem_req;
   assign mem_addr  = {ALUResult_mem[31:2], 2'b00};

   always_comb begin
      wdata_fmt = MemWriteData_mem;
      strb_fmt  = 4'b1111;
      case (funct3_mem[1:0])
         2'b00: begin
            wdata_fmt = {4{MemWriteData_mem[7:0]}};
            strb_fmt  = 4'b0001 << b;
         end
         2'b01: begin
            wdata_fmt = {2{MemWriteData_mem[15:0]}};
            strb_fmt  = 4'b0011 << {b[1], 1'b0};
         end
         default: begin
            wdata_fmt = MemWriteData_mem;
            strb_fmt  = 4'b1111;
         end
      endcase
   end

   assign mem_wdata = wdata_fmt;
   assign mem_wstrb = is_store ? strb_fmt : 4'b0000;

   assign rsh   = mem_rdata >> {b, 3'b000};
   assign lbyte = rsh[7:0];
   assign lhalf = b[1] ? mem_rdata[31:16] : mem_rdata[15:0];

   always_comb begin
      load_fmt = mem_rdata;
      case (funct3_mem)
         3'b000:  load_fmt = {{24{lbyte[7]}}, lbyte};
         3'b100:  load_fmt = {24'h0, lbyte};
         3'b001:  load_fmt = {{16{lhalf[15]}}, lhalf};
         3'b101:  load_fmt = {16'h0, lhalf};
         default: load_fmt = mem_rdata;
      endcase
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         state        <= S_IDLE;
         cnt          <= '0;
         MemDout_mem  <= '0;
         misalign_err <= 1'b0;
         bus_err      <= 1'b0;
      end else begin
         misalign_err <= 1'b0;
         bus_err      <= 1'b0;
         case (state)
            S_IDLE: begin
               if (access) begin
                  if (misaligned) begin
                     misalign_err <= 1'b1;
                     MemDout_mem  <= '0;
                  end else if (mem_ack) begin
                     state <= S_DONE;
                     if (!is_store) MemDout_mem <= load_fmt;
                  end else begin
                     state <= S_WAIT;
                     cnt   <= '0;
                  end
               end
            end
            // Ack is checked before expiry so a late-but-present ack still succeeds.
            S_WAIT: begin
               if (mem_ack) begin
                  state <= S_DONE;
                  if (!is_store) MemDout_mem <= load_fmt;
               end else if ((TIMEOUT != 0) && (cnt == CNT_LAST)) begin
                  bus_err     <= 1'b1;
                  MemDout_mem <= '0;
                  state       <= S_DONE;
               end else begin
                  cnt <= cnt + CNT_ONE;
               end
            end
            S_DONE:  state <= S_IDLE;
            default: state <= S_IDLE;
         endcase
      end
   end

endmodule

// File: tb/tb_mem_stage_lsu.sv
// Directed bench for mem_stage_lsu: table of zero-wait accesses plus hand-written
// wait-state, timeout and reset sequences.
module tb_mem_stage_lsu;

   logic        clk = 1'b0;
   logic        reset;
   logic        MemRead_mem, MemWrite_mem;
   logic [2:0]  funct3_mem;
   logic [31:0] ALUResult_mem, MemWriteData_mem;
   logic        mem_req, mem_we;
   logic [31:0] mem_addr, mem_wdata;
   logic [3:0]  mem_wstrb;
   logic [31:0] mem_rdata;
   logic        mem_ack;
   logic [31:0] MemDout_mem;
   logic        stall_mem, misalign_err, bus_err;

   int pass_cnt  = 0;
   int total_cnt = 0;

   always #5 clk = ~clk;

   mem_stage_lsu #(.TIMEOUT(4), .CNT_W(8)) dut (
      .clk(clk), .reset(reset),
      .MemRead_mem(MemRead_mem), .MemWrite_mem(MemWrite_mem),
      .funct3_mem(funct3_mem), .ALUResult_mem(ALUResult_mem),
      .MemWriteData_mem(MemWriteData_mem),
      .mem_req(mem_req), .mem_we(mem_we), .mem_addr(mem_addr),
      .mem_wdata(mem_wdata), .mem_wstrb(mem_wstrb),
      .mem_rdata(mem_rdata), .mem_ack(mem_ack),
      .MemDout_mem(MemDout_mem), .stall_mem(stall_mem),
      .misalign_err(misalign_err), .bus_err(bus_err)
   );

   typedef struct {
      logic        rd, wr;
      logic [2:0]  f3;
      logic [31:0] addr, data, rdata;
      logic        req, we;
      logic [31:0] eaddr, ewdata;
      logic [3:0]  estrb;
      logic [31:0] edout;
      logic        emis;
   } vec_t;

   vec_t vecs[16];

   task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
      total_cnt++;
      if (act === exp) pass_cnt++;
      else $display("FAIL %s: got %h expected %h", nm, act, exp);
   endtask

   task automatic drive(input logic rd, input logic wr, input logic [2:0] f3,
                        input logic [31:0] addr, input logic [31:0] data);
      MemRead_mem = rd; MemWrite_mem = wr; funct3_mem = f3;
      ALUResult_mem = addr; MemWriteData_mem = data;
   endtask

   task automatic idle_inputs();
      drive(1'b0, 1'b0, 3'b010, 32'h0, 32'h0);
      mem_ack = 1'b0;
   endtask

   // One access with ack already high in the request cycle.
   task automatic run_vec(input vec_t v, input int idx);
      @(posedge clk); #1;
      drive(v.rd, v.wr, v.f3, v.addr, v.data);
      mem_rdata = v.rdata;
      mem_ack   = 1'b1;
      @(negedge clk);
      chk($sformatf("v%0d req", idx),   {31'h0, mem_req},   {31'h0, v.req});
      chk($sformatf("v%0d stall", idx), {31'h0, stall_mem}, {31'h0, v.req});
      chk($sformatf("v%0d we", idx),    {31'h0, mem_we},    {31'h0, v.we});
      chk($sformatf("v%0d addr", idx),  mem_addr,           v.eaddr);
      chk($sformatf("v%0d wdata", idx), mem_wdata,          v.ewdata);
      chk($sformatf("v%0d wstrb", idx), {28'h0, mem_wstrb}, {28'h0, v.estrb});
      @(posedge clk); #1;
      idle_inputs();
      @(negedge clk);
      chk($sformatf("v%0d dout", idx),  MemDout_mem,           v.edout);
      chk($sformatf("v%0d mis", idx),   {31'h0, misalign_err}, {31'h0, v.emis});
      chk($sformatf("v%0d buserr", idx),{31'h0, bus_err},      32'h0);
      chk($sformatf("v%0d stall2", idx),{31'h0, stall_mem},    32'h0);
   endtask

   initial begin
      int nreq, nstall;
      logic seen;
      vec_t v;

      vecs[0]  = '{1,0,3'b000,32'h103,32'h0,32'h80112233, 1,0,32'h100,32'h0,4'b0000,32'hFFFFFF80,0};
      vecs[1]  = '{1,0,3'b100,32'h103,32'h0,32'h80112233, 1,0,32'h100,32'h0,4'b0000,32'h00000080,0};
      vecs[2]  = '{1,0,3'b101,32'h102,32'h0,32'h80112233, 1,0,32'h100,32'h0,4'b0000,32'h00008011,0};
      vecs[3]  = '{1,0,3'b001,32'h102,32'h0,32'h80112233, 1,0,32'h100,32'h0,4'b0000,32'hFFFF8011,0};
      vecs[4]  = '{1,0,3'b010,32'h104,32'h0,32'h12345678, 1,0,32'h104,32'h0,4'b0000,32'h12345678,0};
      vecs[5]  = '{1,0,3'b000,32'h100,32'h0,32'h80112233, 1,0,32'h100,32'h0,4'b0000,32'h00000033,0};
      vecs[6]  = '{1,0,3'b001,32'h100,32'h0,32'h1234F00F, 1,0,32'h100,32'h0,4'b0000,32'hFFFFF00F,0};
      vecs[7]  = '{0,1,3'b001,32'h206,32'h0000ABCD,32'hCAFEBABE, 1,1,32'h204,32'hABCDABCD,4'b1100,32'hFFFFF00F,0};
      vecs[8]  = '{0,1,3'b000,32'h201,32'h0000005A,32'hCAFEBABE, 1,1,32'h200,32'h5A5A5A5A,4'b0010,32'hFFFFF00F,0};
      vecs[9]  = '{0,1,3'b000,32'h203,32'h000000A5,32'hCAFEBABE, 1,1,32'h200,32'hA5A5A5A5,4'b1000,32'hFFFFF00F,0};
      vecs[10] = '{0,1,3'b010,32'h208,32'h11223344,32'hCAFEBABE, 1,1,32'h208,32'h11223344,4'b1111,32'hFFFFF00F,0};
      vecs[11] = '{1,1,3'b010,32'h20C,32'hDEADBEEF,32'h99999999, 1,1,32'h20C,32'hDEADBEEF,4'b1111,32'hFFFFF00F,0};
      vecs[12] = '{1,0,3'b010,32'h102,32'h0,32'h12345678, 0,0,32'h100,32'h0,4'b0000,32'h0,1};
      vecs[13] = '{1,0,3'b001,32'h101,32'h0,32'h12345678, 0,0,32'h100,32'h0,4'b0000,32'h0,1};
      vecs[14] = '{1,0,3'b011,32'h100,32'h0,32'h12345678, 0,0,32'h100,32'h0,4'b0000,32'h0,1};
      vecs[15] = '{1,0,3'b100,32'h101,32'h0,32'h0000AB00, 1,0,32'h100,32'h0,4'b0000,32'h000000AB,0};

      // Reset with a load pending: combinational outputs forced low.
      reset = 1'b1; mem_rdata = 32'h0; mem_ack = 1'b0;
      drive(1'b1, 1'b0, 3'b010, 32'h100, 32'h0);
      @(posedge clk);
      @(negedge clk);
      chk("rst req",   {31'h0, mem_req},      32'h0);
      chk("rst stall", {31'h0, stall_mem},    32'h0);
      chk("rst we",    {31'h0, mem_we},       32'h0);
      chk("rst dout",  MemDout_mem,           32'h0);
      chk("rst mis",   {31'h0, misalign_err}, 32'h0);
      chk("rst bus",   {31'h0, bus_err},      32'h0);
      @(posedge clk); #1;
      reset = 1'b0;
      idle_inputs();

      for (int i = 0; i < 16; i++) run_vec(vecs[i], i);

      // LW with three wait cycles; inputs stay held through DONE (no re-request there).
      @(posedge clk); #1;
      drive(1'b1, 1'b0, 3'b010, 32'h100, 32'h0);
      mem_rdata = 32'hDEADBEEF; mem_ack = 1'b0;
      nreq = 0; nstall = 0;
      for (int i = 0; i < 5; i++) begin
         @(negedge clk);
         nreq   += int'(mem_req);
         nstall += int'(stall_mem);
         if (i == 4) begin
            chk("lw3 dout",  MemDout_mem,        32'hDEADBEEF);
            chk("lw3 stall", {31'h0, stall_mem}, 32'h0);
         end
         mem_ack = (i == 3);
      end
      chk("lw3 req cycles",   nreq,   32'd4);
      chk("lw3 stall cycles", nstall, 32'd4);
      @(posedge clk); #1;
      idle_inputs();

      // Timeout with no ack.
      @(posedge clk); #1;
      drive(1'b1, 1'b0, 3'b010, 32'h300, 32'h0);
      nreq = 0; seen = 1'b0;
      for (int i = 0; i < 20 && !seen; i++) begin
         @(negedge clk);
         if (bus_err) seen = 1'b1;
         else nreq += int'(mem_req);
      end
      chk("to seen",       {31'h0, seen},      32'h1);
      chk("to req cycles", nreq,               32'd5);
      chk("to dout",       MemDout_mem,        32'h0);
      chk("to stall",      {31'h0, stall_mem}, 32'h0);
      chk("to req drop",   {31'h0, mem_req},   32'h0);
      @(posedge clk); #1;
      idle_inputs();
      @(negedge clk);
      chk("to pulse", {31'h0, bus_err}, 32'h0);

      // Ack exactly on the expiry cycle wins.
      @(posedge clk); #1;
      drive(1'b1, 1'b0, 3'b010, 32'h304, 32'h0);
      mem_rdata = 32'h0BADF00D;
      for (int i = 0; i < 6; i++) begin
         @(negedge clk);
         if (i == 5) begin
            chk("exp buserr", {31'h0, bus_err},   32'h0);
            chk("exp dout",   MemDout_mem,        32'h0BADF00D);
            chk("exp stall",  {31'h0, stall_mem}, 32'h0);
         end
         mem_ack = (i == 4);
      end
      @(posedge clk); #1;
      idle_inputs();
      @(negedge clk);
      chk("exp buserr2", {31'h0, bus_err}, 32'h0);

      // Reset while waiting, then a clean access.
      @(posedge clk); #1;
      drive(1'b1, 1'b0, 3'b010, 32'h100, 32'h0);
      @(posedge clk); #1;
      @(negedge clk);
      chk("mid wait req", {31'h0, mem_req}, 32'h1);
      @(posedge clk); #1;
      reset = 1'b1;
      @(negedge clk);
      chk("mid rst req",   {31'h0, mem_req},   32'h0);
      chk("mid rst stall", {31'h0, stall_mem}, 32'h0);
      @(posedge clk); #1;
      reset = 1'b0;
      idle_inputs();
      @(negedge clk);
      chk("post rst dout", MemDout_mem,           32'h0);
      chk("post rst bus",  {31'h0, bus_err},      32'h0);
      chk("post rst mis",  {31'h0, misalign_err}, 32'h0);
      chk("post rst req",  {31'h0, mem_req},      32'h0);
      v = '{1,0,3'b010,32'h108,32'h0,32'h55AA55AA, 1,0,32'h108,32'h0,4'b0000,32'h55AA55AA,0};
      run_vec(v, 99);

      $display("%0d/%0d checks passed", pass_cnt, total_cnt);
      $finish;
   end

endmodule

// File: doc/mem_stage_lsu.md
Name: mem_stage_lsu

Overview:
- Memory-access stage directly downstream of the execute stage in the 5-stage RV32I pipeline.
- Takes the ALU result as the address and the forwarded rs2 value as store data, both through the EX/MEM register.
- Runs a req/ack handshake to the data memory, formats sub-word loads and stores, and stalls the pipeline until the access completes.
- The load result feeds the MEM/WB register.

Parameters:
TIMEOUT, 255, maximum wait cycles for mem_ack before aborting (0 = no timeout)
CNT_W, 8, width of the timeout counter (must hold TIMEOUT)

Ports:
clk  input  1  clock, rising edge
reset  input  1  synchronous, active-high reset
MemRead_mem  input  1  load in MEM stage
MemWrite_mem  input  1  store in MEM stage
funct3_mem  input  3  access size/sign (RV32I load/store funct3)
ALUResult_mem  input  32  effective byte address
MemWriteData_mem  input  32  store data (forwarded rs2)
mem_req  output  1  bus request
mem_we  output  1  bus write enable
mem_addr  output  32  word-aligned address ({ALUResult_mem[31:2],2'b00})
mem_wdata  output  32  lane-replicated store data
mem_wstrb  output  4  byte-lane write strobes
mem_rdata  input  32  read data, valid with mem_ack
mem_ack  input  1  bus completion, one-cycle pulse
MemDout_mem  output  32  formatted load data
stall_mem  output  1  freeze PC, IF/ID, ID/EX and EX/MEM
misalign_err  output  1  one-cycle pulse: misaligned access
bus_err  output  1  one-cycle pulse: ack timeout

Behaviour:
- Reset state: IDLE. Registered outputs clear: MemDout_mem=0, misalign_err=0, bus_err=0, counter=0. While reset is high, combinational outputs mem_req, mem_we and stall_mem are forced to 0.
- access = MemRead_mem | MemWrite_mem. If both are high, treat the access as a store.
- misaligned:
  - Halfword: addr[0]=1.
  - Word: addr[1:0]≠0.
  - Byte: never misaligned.
  - An unsupported funct3 is also treated as misaligned.
- State IDLE:
  - access & !misaligned: drive mem_req=1 and stall_mem=1 combinationally. If mem_ack arrives in the same cycle, go to DONE; otherwise go to WAIT and clear the counter.
  - access & misaligned: no request, stall_mem=0, misalign_err=1 next cycle, MemDout_mem←0. Stay in IDLE.
- State WAIT:
  - mem_req=1 and stall_mem=1. Address, data and strobes stay stable because the upstream registers are frozen.
  - On mem_ack: go to DONE.
  - Otherwise the counter increments. When counter==TIMEOUT-1 (TIMEOUT≠0): drop the request, bus_err=1 next cycle, MemDout_mem←0, go to DONE.
- State DONE:
  - mem_req=0, stall_mem=0. MemDout_mem holds the captured value. The pipeline advances at the end of this cycle. Next state is IDLE.
  - No new request is issued in DONE even if access is still high, because it is the same instruction.
- Latency:
  - Minimum is 1 stall cycle (ack in the IDLE cycle).
  - In general, the stall lasts from the first request cycle through the ack cycle, and the instruction leaves one cycle after the ack.
- Load formatting, captured on the ack cycle. b = addr[1:0], h = addr[1].
  - LB (000): sign-extended byte at lane b.
  - LBU (100): zero-extended byte at lane b.
  - LH (001): sign-extended half h.
  - LHU (101): zero-extended half h.
  - LW (010): full word.
- Stores:
  - SB: wdata = byte replicated ×4, wstrb = 4'b0001<<b.
  - SH: wdata = half replicated ×2, wstrb = 4'b0011<<(2h).
  - SW: wdata = data, wstrb = 4'b1111.
  - mem_we=1 only while mem_req=1 for a store. wstrb=0 for loads.
- Store completion leaves MemDout_mem unchanged.
- mem_ack outside WAIT or IDLE-with-request is ignored.
- A mem_ack in the same cycle as the timeout expiry counts as success: ack wins and bus_err stays 0.
- reset mid-access: state returns to IDLE immediately, mem_req drops the same cycle, and no error pulse is generated.

Test Plan:
- LW at 0x100, ack after 3 wait cycles, rdata=0xDEADBEEF → mem_req high 4 cycles, stall_mem high 4 cycles; DONE cycle MemDout_mem=0xDEADBEEF, stall 0.
- LB addr 0x103, rdata=0x80112233, zero-wait ack → MemDout_mem=0xFFFFFF80. Same access with LBU → 0x00000080. LHU addr 0x102 → 0x00008011.
- SH addr 0x206, data 0x0000ABCD → mem_addr=0x204, mem_wdata=0xABCDABCD, mem_wstrb=4'b1100, mem_we=1. SB addr 0x201, data 0x5A → wstrb=4'b0010, wdata=0x5A5A5A5A.
- LW addr 0x102 → no mem_req, stall 0, misalign_err pulses 1 cycle, MemDout_mem=0.
- TIMEOUT=4, no ack → bus_err pulses once, mem_req drops, stall released after DONE. Ack exactly at the expiry cycle → no bus_err.
- reset asserted in WAIT → next cycle mem_req=0, stall_mem=0, MemDout_mem=0. A following LW with an immediate ack completes normally.
